// File: rtl/pc_gen_ras_super.sv
// N-lane fetch PC generator with early-decode JAL/JALR prediction and a
// circular return address stack restored from backend checkpoints on redirect.
module pc_gen_ras_super #(
    parameter int              XLEN      = 32,
    parameter int              LANES     = 3,
    parameter int              RAS_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    localparam int             PW        = $clog2(RAS_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic [PW-1:0]         redirect_ras_ptr,
    input  logic [PW:0]           redirect_ras_cnt,
    input  logic [LANES-1:0]      lane_valid,
    input  logic [LANES-1:0]      is_jal,
    input  logic [LANES-1:0]      is_jalr,
    input  logic [LANES-1:0]      is_call,
    input  logic [LANES-1:0]      is_ret,
    input  logic [LANES*XLEN-1:0] imm,
    output logic [XLEN-1:0]       imem_addr,
    output logic [LANES*XLEN-1:0] lane_pc,
    output logic [LANES*XLEN-1:0] lane_link,
    output logic [LANES-1:0]      lane_keep,
    output logic                  pred_taken,
    output logic [XLEN-1:0]       pred_target,
    output logic [PW-1:0]         fetch_ras_ptr,
    output logic [PW:0]           fetch_ras_cnt
);

    logic [XLEN-1:0] pc_q;
    logic [PW-1:0]   ras_ptr_q;
    logic [PW:0]     ras_cnt_q;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic            found;
    logic            sel_jal;
    logic            sel_call;
    logic            sel_ret;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_link;
    logic [XLEN-1:0] sel_imm;
    logic [XLEN-1:0] pc_rel_target;
    logic [PW-1:0]   top_idx;
    logic            ras_nonempty;
    logic [XLEN-1:0] next_pc;

    logic            ras_we;
    logic [PW-1:0]   ras_widx;
    logic [PW-1:0]   ras_ptr_d;
    logic [PW:0]     ras_cnt_d;

    assign top_idx       = ras_ptr_q - PW'(1);
    assign ras_nonempty  = (ras_cnt_q != '0);
    assign fetch_ras_ptr = ras_ptr_q;
    assign fetch_ras_cnt = ras_cnt_q;

    // Lane PCs, first-taken-lane scan and selection of that lane's hints.
    always_comb begin
        lane_pc   = '0;
        lane_link = '0;
        lane_keep = '1;
        found     = 1'b0;
        sel_jal   = 1'b0;
        sel_call  = 1'b0;
        sel_ret   = 1'b0;
        sel_pc    = '0;
        sel_link  = '0;
        sel_imm   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_pc[i*XLEN +: XLEN]   = pc_q + XLEN'(4 * i);
            lane_link[i*XLEN +: XLEN] = pc_q + XLEN'(4 * i + 4);
            if (found) begin
                lane_keep[i] = 1'b0;
            end else if (lane_valid[i] && (is_jal[i] || is_jalr[i])) begin
                found    = 1'b1;
                sel_jal  = is_jal[i];
                sel_call = is_call[i];
                sel_ret  = is_ret[i];
                sel_pc   = pc_q + XLEN'(4 * i);
                sel_link = pc_q + XLEN'(4 * i + 4);
                sel_imm  = imm[i*XLEN +: XLEN];
            end
        end
    end

    assign pc_rel_target = sel_pc + (sel_imm & ~XLEN'(3));

    always_comb begin
        pred_taken  = found;
        pred_target = '0;
        if (found) begin
            if (sel_jal) begin
                pred_target = pc_rel_target;
            end else if (sel_ret && ras_nonempty) begin
                pred_target = ras_q[top_idx];
            end else begin
                pred_target = pc_rel_target;
            end
        end
        next_pc = found ? pred_target : pc_q + XLEN'(4 * LANES);
    end

    always_comb begin
        if (!reset) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else if (stall) begin
            imem_addr = pc_q;
        end else begin
            imem_addr = next_pc;
        end
    end

    // A call+return on an empty stack degrades to a plain push.
    always_comb begin
        ras_we    = 1'b0;
        ras_widx  = ras_ptr_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (found) begin
            if (sel_call && sel_ret && ras_nonempty) begin
                ras_we   = 1'b1;
                ras_widx = top_idx;
            end else if (sel_call) begin
                ras_we    = 1'b1;
                ras_widx  = ras_ptr_q;
                ras_ptr_d = ras_ptr_q + PW'(1);
                if (ras_cnt_q < (PW+1)'(RAS_DEPTH)) begin
                    ras_cnt_d = ras_cnt_q + (PW+1)'(1);
                end
            end else if (sel_ret && ras_nonempty) begin
                ras_ptr_d = top_idx;
                ras_cnt_d = ras_cnt_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int unsigned k = 0; k < RAS_DEPTH; k++) begin
                ras_q[k] <= '0;
            end
        end else if (redirect_valid) begin
            pc_q      <= redirect_pc;
            ras_ptr_q <= redirect_ras_ptr;
            ras_cnt_q <= redirect_ras_cnt;
        end else if (!stall) begin
            pc_q      <= next_pc;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_we) begin
                ras_q[ras_widx] <= sel_link;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_ras_super.sv
// Scoreboard bench for pc_gen_ras_super: a behavioural model queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_pc_gen_ras_super;

    localparam int XLEN  = 32;
    localparam int LANES = 3;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam logic [XLEN-1:0] RST_PC = 32'h0;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  stall;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic [PW-1:0]         redirect_ras_ptr;
    logic [PW:0]           redirect_ras_cnt;
    logic [LANES-1:0]      lane_valid, is_jal, is_jalr, is_call, is_ret;
    logic [LANES*XLEN-1:0] imm;
    logic [XLEN-1:0]       imem_addr;
    logic [LANES*XLEN-1:0] lane_pc, lane_link;
    logic [LANES-1:0]      lane_keep;
    logic                  pred_taken;
    logic [XLEN-1:0]       pred_target;
    logic [PW-1:0]         fetch_ras_ptr;
    logic [PW:0]           fetch_ras_cnt;

    pc_gen_ras_super #(.XLEN(XLEN), .LANES(LANES), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ras_ptr(redirect_ras_ptr), .redirect_ras_cnt(redirect_ras_cnt),
        .lane_valid(lane_valid), .is_jal(is_jal), .is_jalr(is_jalr),
        .is_call(is_call), .is_ret(is_ret), .imm(imm),
        .imem_addr(imem_addr), .lane_pc(lane_pc), .lane_link(lane_link),
        .lane_keep(lane_keep), .pred_taken(pred_taken), .pred_target(pred_target),
        .fetch_ras_ptr(fetch_ras_ptr), .fetch_ras_cnt(fetch_ras_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                  rst_n;
        logic                  stall;
        logic                  rv;
        logic [XLEN-1:0]       rpc;
        logic [PW-1:0]         rptr;
        logic [PW:0]           rcnt;
        logic [LANES-1:0]      valid, jal, jalr, call, ret;
        logic [LANES*XLEN-1:0] imm;
    } stim_t;

    typedef struct packed {
        logic [XLEN-1:0]       imem;
        logic [LANES*XLEN-1:0] lpc;
        logic [LANES*XLEN-1:0] link;
        logic [LANES-1:0]      keep;
        logic                  taken;
        logic [XLEN-1:0]       target;
        logic [PW-1:0]         ptr;
        logic [PW:0]           cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: plain integers and an array used as a ring.
    logic [XLEN-1:0] m_pc;
    int              m_ptr, m_cnt;
    logic [XLEN-1:0] m_ras [DEPTH];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        int t;
        logic [XLEN-1:0] base, tgt, nxt;
        e = '0;
        if (!s.rst_n) begin
            m_pc = RST_PC; m_ptr = 0; m_cnt = 0;
            for (int k = 0; k < DEPTH; k++) m_ras[k] = '0;
        end
        t = -1;
        for (int i = 0; i < LANES; i++) begin
            e.lpc[i*XLEN +: XLEN]  = m_pc + 32'(4 * i);
            e.link[i*XLEN +: XLEN] = m_pc + 32'(4 * i + 4);
            if (t < 0 && s.valid[i] && (s.jal[i] || s.jalr[i])) t = i;
        end
        for (int i = 0; i < LANES; i++) e.keep[i] = (t < 0) || (i <= t);
        e.taken = (t >= 0);
        tgt  = '0;
        base = m_pc + 32'(4 * t);
        if (t >= 0) begin
            if (!s.jal[t] && s.ret[t] && m_cnt > 0) tgt = m_ras[(m_ptr + DEPTH - 1) % DEPTH];
            else tgt = base + (s.imm[t*XLEN +: XLEN] & ~32'h3);
        end
        nxt      = (t >= 0) ? tgt : m_pc + 32'(4 * LANES);
        e.target = tgt;
        e.imem   = !s.rst_n ? RST_PC : s.rv ? s.rpc : s.stall ? m_pc : nxt;
        e.ptr    = PW'(m_ptr);
        e.cnt    = (PW+1)'(m_cnt);
        if (!s.rst_n) return;
        if (s.rv) begin
            m_pc = s.rpc; m_ptr = int'(s.rptr); m_cnt = int'(s.rcnt);
        end else if (!s.stall) begin
            m_pc = nxt;
            if (t >= 0) begin
                if (s.call[t] && s.ret[t] && m_cnt > 0) begin
                    m_ras[(m_ptr + DEPTH - 1) % DEPTH] = base + 4;
                end else if (s.call[t]) begin
                    m_ras[m_ptr] = base + 4;
                    m_ptr = (m_ptr + 1) % DEPTH;
                    if (m_cnt < DEPTH) m_cnt++;
                end else if (s.ret[t] && m_cnt > 0) begin
                    m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                    m_cnt--;
                end
            end
        end
    endtask

    task automatic cycle(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s.rst_n; stall = s.stall; redirect_valid = s.rv;
        redirect_pc = s.rpc; redirect_ras_ptr = s.rptr; redirect_ras_cnt = s.rcnt;
        lane_valid = s.valid; is_jal = s.jal; is_jalr = s.jalr;
        is_call = s.call; is_ret = s.ret; imm = s.imm;
        model_step(s, e);
        sb_q.push_back(e);
        #3;
    endtask

    function automatic stim_t redir(logic [XLEN-1:0] pc, int ptr, int cnt);
        stim_t s = idle();
        s.rv = 1'b1; s.rpc = pc; s.rptr = PW'(ptr); s.rcnt = (PW+1)'(cnt);
        return s;
    endfunction

    function automatic stim_t one_lane(int ln, bit jal, bit call, bit ret, logic [XLEN-1:0] im);
        stim_t s = idle();
        s.valid[ln] = 1'b1; s.jal[ln] = jal; s.jalr[ln] = !jal;
        s.call[ln] = call; s.ret[ln] = ret; s.imm[ln*XLEN +: XLEN] = im;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        for (int i = 0; i < LANES; i++) begin
            int r = $urandom_range(0, 9);
            s.valid[i] = ($urandom_range(0, 4) != 0);
            s.jal[i]   = (r < 2);
            s.jalr[i]  = (r >= 2 && r < 4);
            s.call[i]  = ($urandom_range(0, 2) == 0);
            s.ret[i]   = !s.jal[i] && ($urandom_range(0, 1) == 0);
            s.imm[i*XLEN +: XLEN] = $urandom;
        end
        s.stall = ($urandom_range(0, 6) == 0);
        if ($urandom_range(0, 19) == 0) begin
            s.rv = 1'b1; s.rpc = $urandom;
            s.rptr = PW'($urandom_range(0, DEPTH - 1));
            s.rcnt = (PW+1)'($urandom_range(0, DEPTH));
        end
        if ($urandom_range(0, 99) == 0) s.rst_n = 1'b0;
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("imem_addr",   128'(imem_addr),     128'(e.imem));
                chk("lane_pc",     128'(lane_pc),       128'(e.lpc));
                chk("lane_link",   128'(lane_link),     128'(e.link));
                chk("lane_keep",   128'(lane_keep),     128'(e.keep));
                chk("pred_taken",  128'(pred_taken),    128'(e.taken));
                chk("pred_target", 128'(pred_target),   128'(e.target));
                chk("ras_ptr",     128'(fetch_ras_ptr), 128'(e.ptr));
                chk("ras_cnt",     128'(fetch_ras_cnt), 128'(e.cnt));
            end
        end
    end

    initial begin : driver
        stim_t s;
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        redirect_ras_ptr = '0; redirect_ras_cnt = '0; lane_valid = '0;
        is_jal = '0; is_jalr = '0; is_call = '0; is_ret = '0; imm = '0;
        s = idle(); s.rst_n = 1'b0;
        cycle(s); cycle(s);
        chk("imem_in_reset", 128'(imem_addr), 128'(RST_PC));

        // Sequential groups after reset release.
        cycle(idle());
        chk("rst_lane_pc", 128'(lane_pc), 128'(96'h00000008_00000004_00000000));
        chk("rst_imem", 128'(imem_addr), 128'h0C);
        cycle(idle());
        chk("seq_pc1", 128'(lane_pc[31:0]), 128'h0C);
        cycle(idle());
        chk("seq_pc2", 128'(lane_pc[31:0]), 128'h18);

        // JAL in lane1 kills lane2's JAL.
        cycle(redir(32'h100, 0, 0));
        s = one_lane(1, 1, 0, 0, 32'h40);
        s.valid[2] = 1'b1; s.jal[2] = 1'b1; s.imm[64 +: 32] = 32'h400;
        cycle(s);
        chk("jal_keep", 128'(lane_keep), 128'b011);
        chk("jal_target", 128'(pred_target), 128'h144);
        cycle(idle());
        chk("jal_next_pc", 128'(lane_pc[31:0]), 128'h144);

        // Call then returns, including return on an empty stack.
        cycle(redir(32'h200, 0, 0));
        cycle(one_lane(0, 1, 1, 0, 32'h1000));
        chk("call_target", 128'(pred_target), 128'h1200);
        s = one_lane(2, 0, 0, 1, 32'h10);
        cycle(s);
        chk("ret_target", 128'(pred_target), 128'h204);
        chk("ret_cnt_before", 128'(fetch_ras_cnt), 128'd1);
        cycle(one_lane(0, 0, 0, 1, 32'h20));
        chk("ret_empty_cnt", 128'(fetch_ras_cnt), 128'd0);
        chk("ret_empty_target", 128'(pred_target), 128'h224);
        cycle(idle());
        chk("ret_empty_cnt_after", 128'(fetch_ras_cnt), 128'd0);

        // Nine calls overflow the 8-entry stack; nine returns drain it.
        cycle(redir(32'h0, 0, 0));
        for (int k = 0; k < 9; k++) cycle(one_lane(0, 1, 1, 0, 32'h100));
        for (int k = 0; k < 9; k++) begin
            cycle(one_lane(0, 0, 0, 1, 32'h8));
            if (k == 0) chk("ovf_cnt_sat", 128'(fetch_ras_cnt), 128'd8);
            if (k < 8) chk("ovf_ret", 128'(pred_target), 128'(32'h804 - 32'h100 * k));
            else chk("ovf_fallback", 128'(pred_target), 128'h10C);
        end

        // Redirect beats stall; stalled JAL leaves state untouched.
        s = redir(32'h8000, 3, 3);
        s.stall = 1'b1; s.valid[0] = 1'b1; s.jal[0] = 1'b1; s.call[0] = 1'b1;
        s.imm[31:0] = 32'h40;
        cycle(s);
        chk("redir_imem", 128'(imem_addr), 128'h8000);
        for (int k = 0; k < 3; k++) begin
            s = one_lane(0, 1, 1, 0, 32'h40);
            s.stall = 1'b1;
            cycle(s);
            chk("stall_pc", 128'(lane_pc[31:0]), 128'h8000);
            chk("stall_imem", 128'(imem_addr), 128'h8000);
            chk("stall_ptr", 128'(fetch_ras_ptr), 128'd3);
            chk("stall_cnt", 128'(fetch_ras_cnt), 128'd3);
        end

        for (int n = 0; n < 3000; n++) cycle(rand_stim());

        s = idle(); s.rst_n = 1'b0;
        cycle(s);
        chk("final_reset_imem", 128'(imem_addr), 128'(RST_PC));
        cycle(idle());
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
